// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 slave exposing an accelerometer-style register map.
// All logic runs on clk; SCLK/CS/MOSI are double-flop synchronized and edge-detected.
// Frame: command byte (0x0B read / 0x0A write), address byte (bits[5:0]), then data bytes.
// Optional feature: define SPI_RESP_BURST_EN to auto-increment the address per data byte.
// Ports:
//   clk, resetn            system clock, async active-low reset
//   SCLK, CS, MOSI         SPI inputs from the master (CS active-low)
//   MISO                   SPI serial data out, MSB first
//   x/y/z_value [15:0]     live axis samples, snapshotted at frame start
//   wr_valid               one-clk pulse per completed write data byte
//   wr_addr [5:0]          address of that write
//   wr_data [7:0]          data byte of that write
//   busy                   high while synchronized CS is low
module spi_accel_responder (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] x_value,
  input  logic [15:0] y_value,
  input  logic [15:0] z_value,
  output logic        wr_valid,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CFG_N    = 16;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA} state_t;
  typedef enum logic [1:0] {MODE_NONE, MODE_RD, MODE_WR} mode_t;

  state_t              r_state;
  mode_t               r_mode;
  logic [1:0]          r_sclk_sync;
  logic [1:0]          r_cs_sync;
  logic [1:0]          r_mosi_sync;
  logic                r_sclk_d;
  logic                r_cs_d;
  logic [2:0]          r_bit_cnt;
  logic [BYTE_W-2:0]   r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic [BYTE_W-1:0]   r_tx;
  logic [BYTE_W-1:0]   r_cfg [CFG_N];
  logic [SAMPLE_W-1:0] r_snap_x;
  logic [SAMPLE_W-1:0] r_snap_y;
  logic [SAMPLE_W-1:0] r_snap_z;
  logic                r_miso;
  logic                r_wr_valid;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [BYTE_W-1:0]   r_wr_data;
  logic                r_busy;

  logic                w_sclk;
  logic                w_cs;
  logic                w_mosi;
  logic                w_sclk_rise;
  logic                w_sclk_fall;
  logic                w_cs_fall;
  logic [BYTE_W-1:0]   w_byte;
  logic                w_byte_done;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [BYTE_W-1:0]   w_rd_data;

  assign w_sclk      = r_sclk_sync[1];
  assign w_cs        = r_cs_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_RESP_BURST_EN
  assign w_next_addr = r_addr + 6'd1;
`else
  assign w_next_addr = r_addr;
`endif

  // Byte to preload for transmit: the freshly received address, or the next data address.
  assign w_rd_addr = (r_state == ST_ADDR) ? w_byte[ADDR_W-1:0] : w_next_addr;

  // Register map read mux
  always_comb begin
    w_rd_data = 8'h00;
    if (w_rd_addr[5:4] == 2'b10) begin
      w_rd_data = r_cfg[w_rd_addr[3:0]];
    end else begin
      case (w_rd_addr)
        6'h00:   w_rd_data = 8'hAD;
        6'h01:   w_rd_data = 8'h1D;
        6'h02:   w_rd_data = 8'hF2;
        6'h0E:   w_rd_data = r_snap_x[7:0];
        6'h0F:   w_rd_data = r_snap_x[15:8];
        6'h10:   w_rd_data = r_snap_y[7:0];
        6'h11:   w_rd_data = r_snap_y[15:8];
        6'h12:   w_rd_data = r_snap_z[7:0];
        6'h13:   w_rd_data = r_snap_z[15:8];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  // Input synchronizers and edge-detect history; idle values are CS high, SCLK/MOSI low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], SCLK};
      r_cs_sync   <= {r_cs_sync[0], CS};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  // Frame FSM, shift registers, config storage and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_NONE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_tx       <= '0;
      r_snap_x   <= '0;
      r_snap_y   <= '0;
      r_snap_z   <= '0;
      r_miso     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      for (int unsigned i = 0; i < CFG_N; i++) begin
        r_cfg[i] <= '0;
      end
    end else begin
      r_wr_valid <= 1'b0;
      r_busy     <= ~w_cs;
      if (w_cs) begin
        // CS high aborts any frame; a partial byte is simply dropped
        r_state   <= ST_IDLE;
        r_mode    <= MODE_NONE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_mode    <= MODE_NONE;
              r_bit_cnt <= 3'd0;
              r_snap_x  <= x_value;
              r_snap_y  <= y_value;
              r_snap_z  <= z_value;
            end
          end
          ST_CMD: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_shift   <= w_byte[BYTE_W-2:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_state <= ST_ADDR;
              if (w_byte == CMD_READ) begin
                r_mode <= MODE_RD;
              end else if (w_byte == CMD_WRITE) begin
                r_mode <= MODE_WR;
              end else begin
                r_mode <= MODE_NONE;
              end
            end
          end
          ST_ADDR: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_shift   <= w_byte[BYTE_W-2:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              r_state <= ST_DATA;
              r_addr  <= w_byte[ADDR_W-1:0];
              r_tx    <= w_rd_data;
            end
          end
          ST_DATA: begin
            if (w_sclk_rise) begin
              r_shift   <= w_byte[BYTE_W-2:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              if (r_mode == MODE_WR) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_byte;
                if (r_addr[5:4] == 2'b10) begin
                  r_cfg[r_addr[3:0]] <= w_byte;
                end
              end
              r_addr <= w_next_addr;
              r_tx   <= w_rd_data;
            end else if (w_sclk_fall && (r_mode == MODE_RD)) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MISO     = r_miso;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_accel_responder.sv
// tb_spi_accel_responder: directed self-checking bench for spi_accel_responder.
// Acts as an SPI mode-0 master (SCLK period = 16 clk) and checks read data,
// write strobes, aborts, bad commands and reset behaviour against hand-computed values.
module tb_spi_accel_responder;

`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [15:0] x_value = 16'h0000;
  logic [15:0] y_value = 16'h0000;
  logic [15:0] z_value = 16'h0000;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  // write-strobe log and MISO-high counter, owned by the monitors below
  int         wr_n = 0;
  logic [5:0] wr_a [16];
  logic [7:0] wr_d [16];
  int         miso_hi_cnt = 0;

  logic [7:0] rx_buf [4];
  logic [7:0] dummy;

  spi_accel_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .SCLK     (SCLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .x_value  (x_value),
    .y_value  (y_value),
    .z_value  (z_value),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_valid) begin
      if (wr_n < 16) begin
        wr_a[wr_n] <= wr_addr;
        wr_d[wr_n] <= wr_data;
      end
      wr_n <= wr_n + 1;
    end
    if (MISO === 1'b1) miso_hi_cnt <= miso_hi_cnt + 1;
  end

  // one SPI bit per 16 clk; MISO sampled at the rising SCLK edge
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[3'(7 - i)];
      #80;
      SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      #80;
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    CS = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (10) @(negedge clk);
    CS = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic read_frame(input logic [7:0] addr, input int n);
    cs_start();
    xfer(8'h0B, 8, dummy);
    xfer(addr, 8, dummy);
    for (int i = 0; i < n; i++) xfer(8'h00, 8, rx_buf[i]);
    cs_end();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    n_cmp++; if (wr_addr !== 6'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_read_id();
    cs_start();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b want 1", busy); end
    xfer(8'h0B, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(8'h00, 8, rx_buf[0]);
    cs_end();
    n_cmp++; if (rx_buf[0] !== 8'hAD) begin n_fail++; $display("FAIL read_id0: got %h want ad", rx_buf[0]); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b want 0", busy); end
    read_frame(8'h02, 1);
    n_cmp++; if (rx_buf[0] !== 8'hF2) begin n_fail++; $display("FAIL read_id2: got %h want f2", rx_buf[0]); end
  endtask

  task automatic test_snapshot();
    y_value = 16'h1234;
    cs_start();
    xfer(8'h0B, 8, dummy);
    xfer(8'h10, 8, dummy);
    xfer(8'h00, 8, rx_buf[0]);
    y_value = 16'hFFFF;
    xfer(8'h00, 8, rx_buf[1]);
    cs_end();
    n_cmp++; if (rx_buf[0] !== 8'h34) begin n_fail++; $display("FAIL snap_y_lo: got %h want 34", rx_buf[0]); end
    n_cmp++; if (rx_buf[1] !== (BURST ? 8'h12 : 8'h34)) begin
      n_fail++; $display("FAIL snap_y_2nd: got %h want %h", rx_buf[1], (BURST ? 8'h12 : 8'h34)); end
    x_value = 16'hBEEF;
    z_value = 16'h0102;
    read_frame(8'h0F, 1);
    n_cmp++; if (rx_buf[0] !== 8'hBE) begin n_fail++; $display("FAIL x_hi: got %h want be", rx_buf[0]); end
    read_frame(8'hD2, 1); // bits[7:6] ignored -> 0x12
    n_cmp++; if (rx_buf[0] !== 8'h02) begin n_fail++; $display("FAIL z_lo: got %h want 02", rx_buf[0]); end
  endtask

  task automatic test_write();
    int base;
    base = wr_n;
    cs_start();
    xfer(8'h0A, 8, dummy);
    xfer(8'h20, 8, dummy);
    xfer(8'h5A, 8, dummy);
    xfer(8'hC3, 8, dummy);
    cs_end();
    n_cmp++; if (wr_n - base !== 2) begin n_fail++; $display("FAIL wr_count: got %0d want 2", wr_n - base); end
    n_cmp++; if (wr_a[base] !== 6'h20 || wr_d[base] !== 8'h5A) begin
      n_fail++; $display("FAIL wr0: got %h/%h want 20/5a", wr_a[base], wr_d[base]); end
    n_cmp++; if (wr_a[base+1] !== (BURST ? 6'h21 : 6'h20) || wr_d[base+1] !== 8'hC3) begin
      n_fail++; $display("FAIL wr1: got %h/%h want %h/c3", wr_a[base+1], wr_d[base+1], (BURST ? 6'h21 : 6'h20)); end
    read_frame(8'h20, 2);
    n_cmp++; if (rx_buf[0] !== (BURST ? 8'h5A : 8'hC3)) begin
      n_fail++; $display("FAIL rd_cfg20: got %h want %h", rx_buf[0], (BURST ? 8'h5A : 8'hC3)); end
    n_cmp++; if (rx_buf[1] !== 8'hC3) begin n_fail++; $display("FAIL rd_cfg_2nd: got %h want c3", rx_buf[1]); end
    // read-only target: strobe still fires, storage unchanged
    base = wr_n;
    cs_start();
    xfer(8'h0A, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(8'h55, 8, dummy);
    cs_end();
    n_cmp++; if (wr_n - base !== 1 || wr_a[base] !== 6'h00 || wr_d[base] !== 8'h55) begin
      n_fail++; $display("FAIL wr_ro_strobe: got n=%0d %h/%h want n=1 00/55", wr_n - base, wr_a[base], wr_d[base]); end
    read_frame(8'h00, 1);
    n_cmp++; if (rx_buf[0] !== 8'hAD) begin n_fail++; $display("FAIL ro_unchanged: got %h want ad", rx_buf[0]); end
  endtask

  task automatic test_wrap();
    read_frame(8'h3F, 3);
    n_cmp++; if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL wrap0: got %h want 00", rx_buf[0]); end
    n_cmp++; if (rx_buf[1] !== (BURST ? 8'hAD : 8'h00)) begin
      n_fail++; $display("FAIL wrap1: got %h want %h", rx_buf[1], (BURST ? 8'hAD : 8'h00)); end
    n_cmp++; if (rx_buf[2] !== (BURST ? 8'h1D : 8'h00)) begin
      n_fail++; $display("FAIL wrap2: got %h want %h", rx_buf[2], (BURST ? 8'h1D : 8'h00)); end
  endtask

  task automatic test_abort();
    int base;
    base = wr_n;
    cs_start();
    xfer(8'h0A, 8, dummy);
    xfer(8'h25, 8, dummy);
    xfer(8'hF0, 4, dummy);
    cs_end();
    n_cmp++; if (wr_n !== base) begin n_fail++; $display("FAIL abort_no_wr: got %0d strobes want 0", wr_n - base); end
    n_cmp++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b want 0", MISO); end
    read_frame(8'h25, 1);
    n_cmp++; if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL abort_cfg25: got %h want 00", rx_buf[0]); end
  endtask

  task automatic test_bad_cmd();
    int wbase;
    int mbase;
    wbase = wr_n;
    mbase = miso_hi_cnt;
    cs_start();
    xfer(8'h0D, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(8'hFF, 8, rx_buf[0]);
    xfer(8'hFF, 8, rx_buf[1]);
    cs_end();
    n_cmp++; if (rx_buf[0] !== 8'h00 || rx_buf[1] !== 8'h00) begin
      n_fail++; $display("FAIL bad_cmd_rx: got %h %h want 00 00", rx_buf[0], rx_buf[1]); end
    n_cmp++; if (miso_hi_cnt !== mbase) begin n_fail++; $display("FAIL bad_cmd_miso: got %0d high clks want 0", miso_hi_cnt - mbase); end
    n_cmp++; if (wr_n !== wbase) begin n_fail++; $display("FAIL bad_cmd_wr: got %0d strobes want 0", wr_n - wbase); end
  endtask

  task automatic test_reset_mid_read();
    cs_start();
    xfer(8'h0B, 8, dummy);
    xfer(8'h00, 8, dummy);
    repeat (5) @(negedge clk);
    n_cmp++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL mid_msb: got %b want 1", MISO); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL mid_reset_miso: got %b want 0", MISO); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    CS = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    read_frame(8'h01, 1);
    n_cmp++; if (rx_buf[0] !== 8'h1D) begin n_fail++; $display("FAIL post_reset_read: got %h want 1d", rx_buf[0]); end
    read_frame(8'h20, 1);
    n_cmp++; if (rx_buf[0] !== 8'h00) begin n_fail++; $display("FAIL post_reset_cfg: got %h want 00", rx_buf[0]); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_snapshot();
    test_write();
    test_wrap();
    test_abort();
    test_bad_cmd();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
